iteration_frame_writer: RTL and testbench

Consumer end of the rendering engine's ready/send_data burst interface. Requests bursts of set_size iteration words, buffers them in an internal FIFO, maps each word to an 8-bit colour index, and writes the values sequentially into a pixel frame buffer through a valid/ready memory write port. It tracks the pixel count against total_pixels, signals frame completion, and pulses clear_frame to re-arm the engine.

---
 rtl/iteration_frame_writer.sv | 146 ++++++++++++++
 tb/tb_iteration_frame_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iteration_frame_writer.sv
// Burst consumer for the rendering engine: captures iteration words, colour-maps them
// into a FIFO and streams them to the pixel frame buffer through a valid/ready write port.
module iteration_frame_writer #(
  parameter int unsigned HBI            = 32,
  parameter int unsigned set_size       = 1,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned max_iterations = 255
) (
  input  logic           CLK,
  input  logic           SYS_RESET,
  input  logic           start_frame,
  input  logic [20:0]    total_pixels,
  input  logic           ready,
  output logic           send_data,
  input  logic [HBI-1:0] data,
  input  logic           frame_ready,
  output logic           clear_frame,
  output logic           mem_we,
  output logic [20:0]    mem_addr,
  output logic [7:0]     mem_wdata,
  input  logic           mem_ready,
  output logic           frame_done,
  output logic           short_frame,
  output logic           busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(set_size + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQUEST, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [20:0]     r_total;
  logic [20:0]     r_wr_cnt;
  logic [21:0]     r_req_cnt;
  logic [BW-1:0]   r_burst_cnt;
  logic            r_send_data, r_frame_done, r_clear_frame, r_short, r_busy, r_mem_we;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt;

  logic w_cap, w_push, w_pop, w_room, w_frame_end, w_more, w_start, w_last_word, w_set_short;

  function automatic logic [7:0] f_colour(input logic [HBI-1:0] w);
    if (w >= HBI'(max_iterations))  return 8'h00;
    else if (w > HBI'(255))         return 8'hFF;
    else                            return w[7:0];
  endfunction

  // The first CAPTURE cycle is the send_data handshake; words arrive on the following edges.
  assign w_cap       = (r_state == S_CAPTURE) && !r_send_data;
  assign w_push      = w_cap && (r_req_cnt < {1'b0, r_total});
  assign w_pop       = r_mem_we && mem_ready;
  assign w_room      = (CW'(FIFO_DEPTH) - r_count) >= CW'(set_size);
  assign w_frame_end = (r_wr_cnt == r_total);
  assign w_more      = r_req_cnt < {1'b0, r_total};
  assign w_start     = (r_state == S_IDLE) && start_frame;
  assign w_last_word = w_cap && (r_burst_cnt == BW'(set_size - 1));
  assign w_set_short = (r_state == S_DRAIN) && !w_frame_end && (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state logic; frame end beats a new request, no requests past the last pixel.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_frame) w_state_nxt = (total_pixels == 21'd0) ? S_DONE : S_REQUEST;
      S_REQUEST: begin
        if (w_frame_end)                   w_state_nxt = S_DONE;
        else if (ready && w_room && w_more) w_state_nxt = S_CAPTURE;
        else if (frame_ready && !ready)    w_state_nxt = S_DRAIN;
      end
      S_CAPTURE: if (w_last_word) w_state_nxt = S_REQUEST;
      S_DRAIN:   if (w_frame_end || (r_count == '0)) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_state       <= S_IDLE;
      r_total       <= '0;
      r_wr_cnt      <= '0;
      r_req_cnt     <= '0;
      r_burst_cnt   <= '0;
      r_send_data   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_clear_frame <= 1'b0;
      r_short       <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_we      <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_send_data   <= (r_state == S_REQUEST) && (w_state_nxt == S_CAPTURE);
      r_frame_done  <= (w_state_nxt == S_DONE);
      r_clear_frame <= (w_state_nxt == S_DONE);
      r_busy        <= (w_state_nxt == S_REQUEST) || (w_state_nxt == S_CAPTURE) ||
                       (w_state_nxt == S_DRAIN);
      r_count       <= w_count_nxt;
      r_mem_we      <= (w_count_nxt != '0);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_start) r_total <= total_pixels;

      if (w_start)    r_wr_cnt <= '0;
      else if (w_pop) r_wr_cnt <= r_wr_cnt + 21'd1;

      if (w_start)    r_req_cnt <= '0;
      else if (w_cap) r_req_cnt <= r_req_cnt + 22'd1;

      if (w_start)          r_burst_cnt <= '0;
      else if (w_last_word) r_burst_cnt <= '0;
      else if (w_cap)       r_burst_cnt <= r_burst_cnt + BW'(1);

      if (w_start)          r_short <= 1'b0;
      else if (w_set_short) r_short <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= f_colour(data);
  end

  assign send_data   = r_send_data;
  assign clear_frame = r_clear_frame;
  assign frame_done  = r_frame_done;
  assign short_frame = r_short;
  assign busy        = r_busy;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_wr_cnt;
  assign mem_wdata   = r_mem_we ? r_mem[r_rptr] : 8'h00;

endmodule

// File: tb/tb_iteration_frame_writer.sv
// Bench for iteration_frame_writer: engine model feeds bursts, a scoreboard checks every
// frame-buffer write, frame-level results come from a table plus hand-written corner cases.
module tb_iteration_frame_writer;

  localparam int unsigned HBI   = 32;
  localparam int unsigned SET   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXI  = 1000;

  logic           CLK = 1'b0;
  logic           SYS_RESET, start_frame, ready, frame_ready, mem_ready;
  logic [20:0]    total_pixels;
  logic [HBI-1:0] data;
  logic           send_data, clear_frame, mem_we, frame_done, short_frame, busy;
  logic [20:0]    mem_addr;
  logic [7:0]     mem_wdata;

  iteration_frame_writer #(
    .HBI(HBI), .set_size(SET), .FIFO_DEPTH(DEPTH), .max_iterations(MAXI)
  ) dut (
    .CLK(CLK), .SYS_RESET(SYS_RESET), .start_frame(start_frame), .total_pixels(total_pixels),
    .ready(ready), .send_data(send_data), .data(data), .frame_ready(frame_ready),
    .clear_frame(clear_frame), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .frame_done(frame_done), .short_frame(short_frame), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [20:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  typedef struct {
    int total;
    int mr_mode;
    int exp_bursts;
    int exp_short;
  } frame_vec_t;

  exp_t           sb[$];
  logic [HBI-1:0] word_q[$];
  int errors = 0, checks = 0;
  int n_writes = 0, n_bursts = 0, n_done = 0;
  int pix_idx = 0, cur_total = 0;
  int mr_mode = 0;
  logic prev_send = 1'b0;

  function automatic logic [7:0] colour(input logic [HBI-1:0] w);
    if (w >= HBI'(MAXI)) return 8'h00;
    if (w > HBI'(255))   return 8'hFF;
    return w[7:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: on a send_data handshake, drive SET words on consecutive cycles.
  initial begin
    logic [HBI-1:0] w;
    data = '0;
    forever begin
      @(negedge CLK);
      if (send_data && ready && !SYS_RESET) begin
        n_bursts++;
        @(posedge CLK);
        for (int k = 0; k < SET; k++) begin
          #1;
          if (SYS_RESET) break;
          w = (word_q.size() != 0) ? word_q.pop_front() : HBI'($urandom_range(0, 1300));
          data = w;
          if (pix_idx < cur_total) sb.push_back('{addr: 21'(pix_idx), wdata: colour(w)});
          pix_idx++;
          @(posedge CLK);
        end
      end
    end
  end

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (mr_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ~mem_ready;
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // Write monitor: head of scoreboard must be presented (and held) whenever mem_we is up.
  initial begin
    forever begin
      @(negedge CLK);
      if (!SYS_RESET) begin
        if (mem_we) begin
          if (sb.size() == 0) begin
            check("write_without_expected", 32'(mem_addr), -1);
          end else begin
            check("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
            check("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
            if (mem_ready) begin
              void'(sb.pop_front());
              n_writes++;
            end
          end
        end
        if (send_data) check("send_data_width", 32'(prev_send), 0);
        if (frame_done || clear_frame) check("clear_with_done", 32'(clear_frame), 32'(frame_done));
        if (frame_done) n_done++;
        prev_send = send_data;
      end else begin
        prev_send = 1'b0;
      end
    end
  end

  task automatic begin_frame(input int total);
    @(posedge CLK);
    #1;
    n_writes = 0; n_bursts = 0; n_done = 0;
    cur_total = total; pix_idx = 0;
    total_pixels = 21'(total);
    start_frame = 1'b1;
    @(posedge CLK);
    #1;
    start_frame = 1'b0;
    check("busy_after_start", 32'(busy), (total > 0) ? 1 : 0);
  endtask

  task automatic end_frame(input int exp_writes, input int exp_bursts, input int exp_short);
    int budget;
    budget = 0;
    while (n_done == 0 && budget < 3000) begin
      @(posedge CLK);
      budget++;
    end
    repeat (3) @(negedge CLK);
    check("frame_done_pulses", n_done, 1);
    check("write_count", n_writes, exp_writes);
    check("burst_count", n_bursts, exp_bursts);
    check("short_frame", 32'(short_frame), exp_short);
    check("busy_idle", 32'(busy), 0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic wait_bursts(input int n);
    int budget;
    budget = 0;
    while (n_bursts < n && budget < 500) begin
      @(posedge CLK);
      budget++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_send_data"}, 32'(send_data), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_clear_frame"}, 32'(clear_frame), 0);
    check({tag, "_short_frame"}, 32'(short_frame), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    frame_vec_t vecs[5];
    vecs[0] = '{total: 4,  mr_mode: 0, exp_bursts: 1, exp_short: 0};
    vecs[1] = '{total: 6,  mr_mode: 0, exp_bursts: 2, exp_short: 0};
    vecs[2] = '{total: 13, mr_mode: 1, exp_bursts: 4, exp_short: 0};
    vecs[3] = '{total: 0,  mr_mode: 0, exp_bursts: 0, exp_short: 0};
    vecs[4] = '{total: 8,  mr_mode: 1, exp_bursts: 2, exp_short: 0};

    SYS_RESET = 1'b1; start_frame = 1'b0; ready = 1'b1; frame_ready = 1'b0;
    total_pixels = '0;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    SYS_RESET = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mr_mode = vecs[i].mr_mode;
      if (i == 0) begin
        word_q.push_back(HBI'(3));
        word_q.push_back(HBI'(300));
        word_q.push_back(HBI'(200));
        word_q.push_back(HBI'(1000));
      end
      begin_frame(vecs[i].total);
      end_frame(vecs[i].total, vecs[i].exp_bursts, vecs[i].exp_short);
    end

    // Frame buffer stalled: only two bursts fit, head must hold until released.
    mr_mode = 2;
    begin_frame(12);
    repeat (40) @(negedge CLK);
    check("stall_bursts", n_bursts, 2);
    check("stall_mem_we", 32'(mem_we), 1);
    check("stall_send_data", 32'(send_data), 0);
    mr_mode = 0;
    end_frame(12, 3, 0);

    // Engine finishes early: drain what was sent and flag a short frame.
    mr_mode = 0;
    begin_frame(10);
    wait_bursts(2);
    #1;
    ready = 1'b0;
    frame_ready = 1'b1;
    end_frame(8, 2, 1);
    @(posedge CLK);
    #1;
    ready = 1'b1;
    frame_ready = 1'b0;

    // Reset in the middle of a burst with words already buffered.
    mr_mode = 2;
    begin_frame(12);
    wait_bursts(2);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    SYS_RESET = 1'b1;
    #1;
    check_all_zero("midreset");
    sb.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    SYS_RESET = 1'b0;
    mr_mode = 0;
    begin_frame(5);
    end_frame(5, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
